// File: rtl/decode_queue_pkg.sv
// Shared decode constants: op codes (WOW = illegal), field widths and base opcodes.
package decode_queue_pkg;

  localparam int OP_W  = 6;
  localparam int IMM_W = 32;
  localparam int REG_W = 5;

  localparam logic [OP_W-1:0] OP_WOW   = 6'd0;
  localparam logic [OP_W-1:0] OP_LUI   = 6'd1;
  localparam logic [OP_W-1:0] OP_AUIPC = 6'd2;
  localparam logic [OP_W-1:0] OP_JAL   = 6'd3;
  localparam logic [OP_W-1:0] OP_JALR  = 6'd4;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd5;
  localparam logic [OP_W-1:0] OP_BNE   = 6'd6;
  localparam logic [OP_W-1:0] OP_BLT   = 6'd7;
  localparam logic [OP_W-1:0] OP_BGE   = 6'd8;
  localparam logic [OP_W-1:0] OP_BLTU  = 6'd9;
  localparam logic [OP_W-1:0] OP_BGEU  = 6'd10;
  localparam logic [OP_W-1:0] OP_LB    = 6'd11;
  localparam logic [OP_W-1:0] OP_LH    = 6'd12;
  localparam logic [OP_W-1:0] OP_LW    = 6'd13;
  localparam logic [OP_W-1:0] OP_LBU   = 6'd14;
  localparam logic [OP_W-1:0] OP_LHU   = 6'd15;
  localparam logic [OP_W-1:0] OP_SB    = 6'd16;
  localparam logic [OP_W-1:0] OP_SH    = 6'd17;
  localparam logic [OP_W-1:0] OP_SW    = 6'd18;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd19;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'd20;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'd21;
  localparam logic [OP_W-1:0] OP_XORI  = 6'd22;
  localparam logic [OP_W-1:0] OP_ORI   = 6'd23;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'd24;
  localparam logic [OP_W-1:0] OP_SLLI  = 6'd25;
  localparam logic [OP_W-1:0] OP_SRLI  = 6'd26;
  localparam logic [OP_W-1:0] OP_SRAI  = 6'd27;
  localparam logic [OP_W-1:0] OP_ADD   = 6'd28;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd29;
  localparam logic [OP_W-1:0] OP_SLL   = 6'd30;
  localparam logic [OP_W-1:0] OP_SLT   = 6'd31;
  localparam logic [OP_W-1:0] OP_SLTU  = 6'd32;
  localparam logic [OP_W-1:0] OP_XOR   = 6'd33;
  localparam logic [OP_W-1:0] OP_SRL   = 6'd34;
  localparam logic [OP_W-1:0] OP_SRA   = 6'd35;
  localparam logic [OP_W-1:0] OP_OR    = 6'd36;
  localparam logic [OP_W-1:0] OP_AND   = 6'd37;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [IMM_W-1:0] imm;
    logic             rs1_query;
    logic             rs2_query;
    logic             to_lsb;
  } dec_t;

endpackage

// File: rtl/decode_queue_fields.sv
// Combinational decode of one instruction word into op, immediate, queries and routing.
module decode_fields
  import decode_queue_pkg::*;
(
  input  logic [31:0] ins,
  output dec_t        dec
);

  logic [6:0]       opc;
  logic [2:0]       f3;
  logic             alt;
  logic [OP_W-1:0]  op;
  logic [IMM_W-1:0] imm_u, imm_j, imm_i, imm_b, imm_s;

  assign opc = ins[6:0];
  assign f3  = ins[14:12];
  assign alt = ins[30];

  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_b = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};

  always_comb begin
    op = OP_WOW;
    case (opc)
      OPC_LUI:   op = OP_LUI;
      OPC_AUIPC: op = OP_AUIPC;
      OPC_JAL:   op = OP_JAL;
      OPC_JALR:  op = (f3 == 3'b000) ? OP_JALR : OP_WOW;
      OPC_BRANCH:
        case (f3)
          3'b000:  op = OP_BEQ;
          3'b001:  op = OP_BNE;
          3'b100:  op = OP_BLT;
          3'b101:  op = OP_BGE;
          3'b110:  op = OP_BLTU;
          3'b111:  op = OP_BGEU;
          default: op = OP_WOW;
        endcase
      OPC_LOAD:
        case (f3)
          3'b000:  op = OP_LB;
          3'b001:  op = OP_LH;
          3'b010:  op = OP_LW;
          3'b100:  op = OP_LBU;
          3'b101:  op = OP_LHU;
          default: op = OP_WOW;
        endcase
      OPC_STORE:
        case (f3)
          3'b000:  op = OP_SB;
          3'b001:  op = OP_SH;
          3'b010:  op = OP_SW;
          default: op = OP_WOW;
        endcase
      OPC_OPIMM:
        case (f3)
          3'b000:  op = OP_ADDI;
          3'b001:  op = OP_SLLI;
          3'b010:  op = OP_SLTI;
          3'b011:  op = OP_SLTIU;
          3'b100:  op = OP_XORI;
          3'b101:  op = alt ? OP_SRAI : OP_SRLI;
          3'b110:  op = OP_ORI;
          default: op = OP_ANDI;
        endcase
      OPC_OP:
        case (f3)
          3'b000:  op = alt ? OP_SUB : OP_ADD;
          3'b001:  op = OP_SLL;
          3'b010:  op = OP_SLT;
          3'b011:  op = OP_SLTU;
          3'b100:  op = OP_XOR;
          3'b101:  op = alt ? OP_SRA : OP_SRL;
          3'b110:  op = OP_OR;
          default: op = OP_AND;
        endcase
      default: op = OP_WOW;
    endcase
  end

  // Illegal encodings keep everything but op at zero so they route to RS inertly.
  always_comb begin
    dec    = '0;
    dec.op = op;
    if (op != OP_WOW) begin
      case (opc)
        OPC_LUI, OPC_AUIPC: dec.imm = imm_u;
        OPC_JAL:            dec.imm = imm_j;
        OPC_JALR: begin
          dec.imm       = imm_i;
          dec.rs1_query = 1'b1;
        end
        OPC_BRANCH: begin
          dec.imm       = imm_b;
          dec.rs1_query = 1'b1;
          dec.rs2_query = 1'b1;
        end
        OPC_LOAD: begin
          dec.imm       = imm_i;
          dec.rs1_query = 1'b1;
          dec.to_lsb    = 1'b1;
        end
        OPC_STORE: begin
          dec.imm       = imm_s;
          dec.rs1_query = 1'b1;
          dec.rs2_query = 1'b1;
          dec.to_lsb    = 1'b1;
        end
        OPC_OPIMM: begin
          dec.imm       = imm_i;
          dec.rs1_query = 1'b1;
        end
        OPC_OP: begin
          dec.rs1_query = 1'b1;
          dec.rs2_query = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/decode_queue.sv
// Circular instruction queue between fetch and issue; decodes the head and issues it
// as a registered one-cycle pulse when the structures it needs have room.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int INS_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rdy,
  input  logic               flush,
  input  logic               ifq_valid,
  input  logic [INS_W-1:0]   ifq_ins,
  input  logic [PC_W-1:0]    ifq_pc,
  input  logic [PC_W-1:0]    ifq_pred_pc,
  output logic               ifq_full,
  input  logic               rob_full,
  input  logic               rs_full,
  input  logic               lsb_full,
  output logic               out_valid,
  output logic [OP_W-1:0]    out_op,
  output logic [REG_W-1:0]   out_rd,
  output logic [IMM_W-1:0]   out_imm,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_pred_pc,
  output logic               out_to_lsb,
  output logic               rs1_query,
  output logic [REG_W-1:0]   rs1_pos,
  output logic               rs2_query,
  output logic [REG_W-1:0]   rs2_pos
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INS_W-1:0] ins_mem  [DEPTH];
  logic [PC_W-1:0]  pc_mem   [DEPTH];
  logic [PC_W-1:0]  pred_mem [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [INS_W-1:0] head_ins;
  dec_t             hd;
  logic             unit_free, do_issue, do_enq;

  assign ifq_full = (count == CNT_W'(DEPTH));
  assign head_ins = ins_mem[head];

  decode_fields u_fields (
    .ins (head_ins[31:0]),
    .dec (hd)
  );

  assign unit_free = hd.to_lsb ? !lsb_full : !rs_full;
  assign do_issue  = rdy && !flush && (count != '0) && !rob_full && unit_free;
  assign do_enq    = rdy && !flush && ifq_valid && !ifq_full;

  always_ff @(posedge clk) begin
    if (rst_n && do_enq) begin
      ins_mem[tail]  <= ifq_ins;
      pc_mem[tail]   <= ifq_pc;
      pred_mem[tail] <= ifq_pred_pc;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_enq)   tail <= tail + PTR_W'(1);
        if (do_issue) head <= head + PTR_W'(1);
        count <= count + CNT_W'(do_enq) - CNT_W'(do_issue);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || (rdy && !do_issue)) begin
      out_valid   <= 1'b0;
      out_op      <= '0;
      out_rd      <= '0;
      out_imm     <= '0;
      out_pc      <= '0;
      out_pred_pc <= '0;
      out_to_lsb  <= 1'b0;
      rs1_query   <= 1'b0;
      rs1_pos     <= '0;
      rs2_query   <= 1'b0;
      rs2_pos     <= '0;
    end else if (rdy) begin
      out_valid   <= 1'b1;
      out_op      <= hd.op;
      out_rd      <= head_ins[11:7];
      out_imm     <= hd.imm;
      out_pc      <= pc_mem[head];
      out_pred_pc <= pred_mem[head];
      out_to_lsb  <= hd.to_lsb;
      rs1_query   <= hd.rs1_query;
      rs1_pos     <= head_ins[19:15];
      rs2_query   <= hd.rs2_query;
      rs2_pos     <= head_ins[24:20];
    end
  end

endmodule
